// File: rtl/pc_defs_pkg.sv
// Shared definitions for the PC generator slice.
//   pc_state_t           : FSM encodings BOOT / RUN / HOLD
//   PC_INCREMENT         : sequential fetch stride
//   DEFAULT_RESET_VECTOR : PC presented when leaving BOOT
//   DEFAULT_TRAP_VECTOR  : PC loaded on a misaligned redirect target
//   HIGH / LOW           : logic level constants
package pc_defs_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_INCREMENT         = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

endpackage

// File: rtl/pc_redirect_buffer.sv
// Holds one redirect target that arrived while the front end was stalled.
//   CLK         in   clock
//   RST         in   synchronous active-high reset, clears the pending flag
//   LOAD        in   capture TARGET (a newer target overwrites an older one)
//   DRAIN       in   redirect consumed, clear the pending flag
//   TARGET      in   32-bit redirect target to capture
//   PEND_TARGET out  buffered target
//   PENDING     out  a buffered target is waiting
module pc_redirect_buffer
  import pc_defs_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        LOAD,
  input  logic        DRAIN,
  input  logic [31:0] TARGET,
  output logic [31:0] PEND_TARGET,
  output logic        PENDING
);

  logic [31:0] pend_reg;
  logic        pending_reg;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_reg    <= '0;
      pending_reg <= LOW;
    end else if (LOAD) begin
      // Load takes priority: the latest target seen during the stall wins.
      pend_reg    <= TARGET;
      pending_reg <= HIGH;
    end else if (DRAIN) begin
      pending_reg <= LOW;
    end
  end

  assign PEND_TARGET = pend_reg;
  assign PENDING     = pending_reg;

endmodule

// File: rtl/pc_generator.sv
// Owns the architectural PC and drives the fetch register PC_IN / PC_VALID_IN.
// Sequential +4 fetch, branch/jump redirects from EX, redirects arriving under
// stall are buffered until the stall releases, and a boot delay keeps the PC
// invalid after reset until instruction memory is ready.
// Optional feature macro: PC_MISALIGN_TRAP_EN
//   defined   : a misaligned redirect target loads TRAP_VECTOR and pulses MISALIGN_TRAP
//   undefined : target[1:0] is forced to 2'b00, MISALIGN_TRAP port is absent
// Ports:
//   CLK                in   clock
//   RST                in   synchronous active-high reset
//   STALL_PC_GENERATOR in   hold the PC
//   BRANCH_TAKEN       in   redirect request from EX (level)
//   BRANCH_TARGET      in   32-bit redirect target
//   PC_OUT             out  current PC (registered)
//   PC_VALID_OUT       out  PC_OUT is a correct-path fetch address
//   REDIRECT_PENDING   out  buffered redirect waiting for stall release
//   MISALIGN_TRAP      out  one-cycle misaligned-target pulse (macro only)
module pc_generator
  import pc_defs_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int unsigned BOOT_DELAY   = 2,
  parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        STALL_PC_GENERATOR,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] PC_OUT,
  output logic        PC_VALID_OUT,
`ifdef PC_MISALIGN_TRAP_EN
  output logic        MISALIGN_TRAP,
`endif
  output logic        REDIRECT_PENDING
);

  pc_state_t   state_reg, state_next;
  logic [7:0]  boot_cnt_reg, boot_cnt_next;
  logic [31:0] pc_reg, pc_next;
  logic        trap_reg, trap_next;

  logic        buf_load, buf_drain, redirect_en;
  logic [31:0] pend_target, redirect_src, redirect_pc;
  logic        pending, misaligned;

  pc_redirect_buffer u_redirect_buffer (
    .CLK         (CLK),
    .RST         (RST),
    .LOAD        (buf_load),
    .DRAIN       (buf_drain),
    .TARGET      (BRANCH_TARGET),
    .PEND_TARGET (pend_target),
    .PENDING     (pending)
  );

  // On stall release a live redirect beats the buffered one, being newer.
  assign redirect_src = (state_reg == HOLD && !BRANCH_TAKEN) ? pend_target : BRANCH_TARGET;
  assign misaligned   = |redirect_src[1:0];

`ifdef PC_MISALIGN_TRAP_EN
  assign redirect_pc = misaligned ? TRAP_VECTOR : redirect_src;
`else
  assign redirect_pc = {redirect_src[31:2], 2'b00};
  wire unused_trap_vector = ^TRAP_VECTOR;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg    <= BOOT;
      boot_cnt_reg <= 8'(BOOT_DELAY);
      pc_reg       <= RESET_VECTOR;
      trap_reg     <= LOW;
    end else begin
      state_reg    <= state_next;
      boot_cnt_reg <= boot_cnt_next;
      pc_reg       <= pc_next;
      trap_reg     <= trap_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    boot_cnt_next = boot_cnt_reg;
    pc_next       = pc_reg;
    buf_load      = LOW;
    buf_drain     = LOW;
    redirect_en   = LOW;
    case (state_reg)
      BOOT: begin
        // Stall and branches are ignored while instruction memory wakes up.
        // A delay of 0 or 1 both leave BOOT on the first cycle.
        boot_cnt_next = (boot_cnt_reg == 8'd0) ? 8'd0 : boot_cnt_reg - 8'd1;
        if (boot_cnt_reg <= 8'd1) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (BRANCH_TAKEN) begin
          if (STALL_PC_GENERATOR) begin
            buf_load   = HIGH;
            state_next = HOLD;
          end else begin
            redirect_en = HIGH;
          end
        end else if (!STALL_PC_GENERATOR) begin
          pc_next = pc_reg + PC_INCREMENT;
        end
      end
      HOLD: begin
        if (STALL_PC_GENERATOR) begin
          buf_load = BRANCH_TAKEN;
        end else begin
          redirect_en = HIGH;
          buf_drain   = HIGH;
          state_next  = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
    if (redirect_en) begin
      pc_next = redirect_pc;
    end
  end

`ifdef PC_MISALIGN_TRAP_EN
  assign trap_next     = redirect_en & misaligned;
  assign MISALIGN_TRAP = trap_reg;
`else
  assign trap_next = LOW;
  wire unused_trap = trap_reg;
`endif

  assign PC_OUT           = pc_reg;
  // In HOLD pc_reg is wrong-path, so it is not offered to fetch.
  assign PC_VALID_OUT     = (state_reg == RUN);
  assign REDIRECT_PENDING = pending;

endmodule

// File: tb/tb_pc_generator.sv
// Self-checking bench for pc_generator (default parameters).
// Each driven cycle pushes the outputs expected after the next rising edge;
// the monitor pops and compares #1 after that edge.
module tb_pc_generator;

`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TRAP_ON = 1'b1;
`else
  localparam bit TRAP_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        STALL_PC_GENERATOR = 1'b0;
  logic        BRANCH_TAKEN = 1'b0;
  logic [31:0] BRANCH_TARGET = '0;
  logic [31:0] PC_OUT;
  logic        PC_VALID_OUT;
  logic        REDIRECT_PENDING;
`ifdef PC_MISALIGN_TRAP_EN
  logic        MISALIGN_TRAP;
`endif

  pc_generator dut (
    .CLK                (CLK),
    .RST                (RST),
    .STALL_PC_GENERATOR (STALL_PC_GENERATOR),
    .BRANCH_TAKEN       (BRANCH_TAKEN),
    .BRANCH_TARGET      (BRANCH_TARGET),
    .PC_OUT             (PC_OUT),
    .PC_VALID_OUT       (PC_VALID_OUT),
`ifdef PC_MISALIGN_TRAP_EN
    .MISALIGN_TRAP      (MISALIGN_TRAP),
`endif
    .REDIRECT_PENDING   (REDIRECT_PENDING)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        chk;
    logic [31:0] pc;
    logic        valid;
    logic        pend;
    logic        trap;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic rst, input logic stall, input logic bt, input logic [31:0] tgt,
                      input logic chk, input logic [31:0] pc, input logic valid,
                      input logic pend, input logic trap);
    exp_t e;
    @(negedge CLK);
    RST                = rst;
    STALL_PC_GENERATOR = stall;
    BRANCH_TAKEN       = bt;
    BRANCH_TARGET      = tgt;
    e.chk = chk; e.pc = pc; e.valid = valid; e.pend = pend; e.trap = trap;
    exp_q.push_back(e);
  endtask

  always @(posedge CLK) begin : monitor
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.chk) begin
        txn++;
        $display("txn %0d pc=%h valid=%b pend=%b exp_pc=%h", txn, PC_OUT, PC_VALID_OUT,
                 REDIRECT_PENDING, e.pc);
        check("pc", PC_OUT, e.pc);
        check("valid", {31'd0, PC_VALID_OUT}, {31'd0, e.valid});
        check("pending", {31'd0, REDIRECT_PENDING}, {31'd0, e.pend});
`ifdef PC_MISALIGN_TRAP_EN
        check("trap", {31'd0, MISALIGN_TRAP}, {31'd0, e.trap});
`endif
      end
    end
  end

  initial begin
    //   rst stall bt  target         chk pc             valid pend trap
    // Reset state, then 2 boot cycles invalid, then 0,4,8...
    step(1, 0, 0, 32'h0,           1, 32'h0,          0, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h0,          0, 0, 0);
    step(0, 1, 1, 32'h0000_0900,   1, 32'h0,          1, 0, 0); // stall/branch ignored in BOOT
    step(0, 0, 0, 32'h0,           1, 32'h4,          1, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h8,          1, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'hC,          1, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h10,         1, 0, 0);
    // Stall holds 0x10 valid, release -> 0x14
    for (int i = 0; i < 3; i++)
      step(0, 1, 0, 32'h0,         1, 32'h10,         1, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h14,         1, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h18,         1, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h1C,         1, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h20,         1, 0, 0);
    // Unstalled redirect
    step(0, 0, 1, 32'h80,          1, 32'h80,         1, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h84,         1, 0, 0);
    step(0, 0, 1, 32'h40,          1, 32'h40,         1, 0, 0);
    // Redirect under stall, latest target wins, release without BRANCH_TAKEN
    step(0, 1, 1, 32'h200,         1, 32'h40,         0, 1, 0);
    step(0, 1, 1, 32'h200,         1, 32'h40,         0, 1, 0);
    step(0, 1, 1, 32'h300,         1, 32'h40,         0, 1, 0);
    step(0, 0, 0, 32'h0,           1, 32'h300,        1, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h304,        1, 0, 0);
    // Release with a live redirect overrides the buffered one
    step(0, 1, 1, 32'h500,         1, 32'h304,        0, 1, 0);
    step(0, 1, 0, 32'h0,           1, 32'h304,        0, 1, 0);
    step(0, 0, 1, 32'h600,         1, 32'h600,        1, 0, 0);
    // Wrap at top of address space
    step(0, 0, 1, 32'hFFFF_FFFC,   1, 32'hFFFF_FFFC,  1, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h0,          1, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h4,          1, 0, 0);
    // Reset while in HOLD
    step(0, 1, 1, 32'h700,         1, 32'h4,          0, 1, 0);
    step(1, 1, 1, 32'h700,         1, 32'h0,          0, 0, 0);
    step(0, 0, 1, 32'h700,         1, 32'h0,          0, 0, 0);
    step(0, 0, 0, 32'h0,           1, 32'h0,          1, 0, 0);
    // Misaligned targets, live and pended
    step(0, 0, 1, 32'h102,         1, 32'h100,        1, 0, TRAP_ON);
    step(0, 0, 0, 32'h0,           1, 32'h104,        1, 0, 0);
    step(0, 1, 1, 32'h203,         1, 32'h104,        0, 1, 0);
    step(0, 0, 0, 32'h0,           1, TRAP_ON ? 32'h100 : 32'h200, 1, 0, TRAP_ON);
    step(0, 1, 0, 32'h0,           1, TRAP_ON ? 32'h100 : 32'h200, 1, 0, 0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge CLK);
    check("drain", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
